// File: rtl/hazard_unit.sv
// Pipeline hazard controller: load-use bubbles, vector memory freezes and
// taken-branch flushes, with saturating stall/flush performance counters.
module hazard_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_memtoreg,
    input  logic             ex_regwrite,
    input  logic             ex_vec_mem,
    input  logic [1:0]       ex_VL,
    input  logic             branch_taken,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             busy,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    // state  | meaning
    // IDLE   | normal issue; branch, vector-entry and load-use decisions made here
    // VSTALL | front end frozen while remaining vector beats drain (cnt = beats left)
    typedef enum logic {IDLE, VSTALL} state_t;

    state_t     state, state_nxt;
    logic [2:0] cnt, cnt_nxt;
    logic       lu;
    logic       stall_inc, flush_inc, freeze, flush_br;

    assign lu = ex_memtoreg & ex_regwrite & (ex_rd != 5'd0) &
                ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                 (id_uses_rs2 & (id_rs2 == ex_rd)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 3'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        freeze    = 1'b0;
        flush_br  = 1'b0;
        case (state)
            IDLE: begin
                if (branch_taken) begin
                    flush_br  = 1'b1;
                    flush_inc = 1'b1;
                end else if (ex_vec_mem && (ex_VL != 2'd0)) begin
                    freeze    = 1'b1;
                    stall_inc = 1'b1;
                    if (ex_VL[1]) begin
                        // Entry cycle is the first frozen beat, so 2^VL-2 remain.
                        state_nxt = VSTALL;
                        cnt_nxt   = (3'd1 << ex_VL) - 3'd2;
                    end
                end else if (lu) begin
                    freeze    = 1'b1;
                    stall_inc = 1'b1;
                end
            end
            VSTALL: begin
                freeze    = 1'b1;
                stall_inc = 1'b1;
                cnt_nxt   = cnt - 3'd1;
                if (cnt == 3'd1)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        busy       = (state == VSTALL);
        if (reset) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            busy       = 1'b0;
        end else if (flush_br) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (freeze) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (stall_inc && (stall_cycles != {CNT_W{1'b1}}))
                stall_cycles <= stall_cycles + 1'b1;
            if (flush_inc && (flush_events != {CNT_W{1'b1}}))
                flush_events <= flush_events + 1'b1;
        end
    end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the 5-stage scalar/vector core. It reads the ID-stage source registers and the EX-stage fields held in the ID/EX register, and drives the freeze and flush controls back into the PC, IF/ID and ID/EX registers. It covers three cases:
- load-use bubbles;
- multi-cycle front-end freezes behind vector memory ops;
- taken-branch flushes.

It also keeps saturating performance counters for stall cycles and flush events.

## Interface
Parameters:
- CNT_W, 16, width of the performance counters

Ports:
- clk  in  1  system clock, all state updates on posedge
- reset  in  1  asynchronous, active-high; clears all state
- id_rs1  in  5  rs1 of the instruction in ID
- id_rs2  in  5  rs2 of the instruction in ID
- id_uses_rs1  in  1  ID instruction reads rs1
- id_uses_rs2  in  1  ID instruction reads rs2
- ex_rd  in  5  rd of the instruction in EX (ID/EX output)
- ex_memtoreg  in  1  EX instruction is a load
- ex_regwrite  in  1  EX instruction writes the scalar regfile
- ex_vec_mem  in  1  EX instruction is a vector load/store (WVR/SVR access)
- ex_VL  in  2  vector length code of the EX instruction; beats = 2^ex_VL
- branch_taken  in  1  branch in EX resolved taken this cycle
- pc_write  out  1  PC update enable
- ifid_write  out  1  IF/ID load enable
- ifid_flush  out  1  zero the IF/ID register
- idex_flush  out  1  zero the ID/EX register (drives ID/EX flush)
- busy  out  1  high while in VSTALL
- stall_cycles  out  CNT_W  saturating count of frozen cycles
- flush_events  out  CNT_W  saturating count of taken-branch flushes

## Operation
- **State:**
  - FSM state, IDLE or VSTALL.
  - Beat counter `cnt`, 3 bits.
  - Two performance counters.
- **Outputs:** combinational from state and inputs. The freeze set is pc_write=0, ifid_write=0, idex_flush=1, ifid_flush=0. The normal set is pc_write=1, ifid_write=1, both flushes 0.
- **Load-use term:** lu = ex_memtoreg & ex_regwrite & (ex_rd!=0) & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- **IDLE**, evaluated in priority order:
  1. branch_taken=1: ifid_flush=1, idex_flush=1, pc_write=1, ifid_write=1. Stay IDLE; flush_events++.
  2. ex_vec_mem=1 and ex_VL!=0: freeze set; stall_cycles++.
     - ex_VL=1: stay IDLE.
     - ex_VL=2 or 3: go to VSTALL with cnt=2^ex_VL-2.
  3. lu=1: freeze set for this cycle only; stay IDLE; stall_cycles++.
  4. Otherwise: normal set.
- **VSTALL:**
  - Freeze set every cycle; stall_cycles++.
  - If cnt==1, go to IDLE; else cnt--.
  - All inputs, including branch_taken, are ignored, because EX holds only bubbles.
- **Total frozen cycles per vector op:** 2^ex_VL-1, i.e. 0/1/3/7 for VL=0/1/2/3. ex_VL=0 with ex_vec_mem=1 is treated as scalar, so the lu rule still applies.
- **Counters:** saturate at 2^CNT_W-1 with no wrap.

## Timing
- **Reset values:** state=IDLE, cnt=0, stall_cycles=0, flush_events=0.
- **Outputs while reset is high:** pc_write=0, ifid_write=0, ifid_flush=1, idex_flush=1, busy=0.
- **Latency:** decisions are zero-latency (same-cycle combinational). State and counter changes take effect at the next posedge.
- **Reset mid-VSTALL:** immediate return to IDLE and the counters clear. No residual freeze after reset deasserts.
- **Simultaneous events:**
  - branch_taken with lu: branch wins; no stall.
  - ex_vec_mem with lu: vector rule wins; lu is covered by the first frozen cycle.
- **busy:** equals (state==VSTALL); it is low during the entry cycle.
- **Counter updates:** each counter increments at most once per cycle.

## Test plan
- **Load-use:** ex_memtoreg=1, ex_regwrite=1, ex_rd=5, id_uses_rs2=1, id_rs2=5 for one cycle -> freeze for exactly 1 cycle, stall_cycles=1, state stays IDLE. Repeating with ex_rd=0 -> no stall.
- **Vector VL=3:** ex_vec_mem=1, ex_VL=3 for one cycle, then idle inputs -> pc_write=0 for exactly 7 consecutive cycles and busy high for cycles 2-7. Afterwards pc_write=1 and stall_cycles=7.
- **Vector VL=1 and VL=0:** VL=1 -> single-cycle freeze with busy never high. VL=0 with no lu -> no freeze.
- **Branch priority:** branch_taken=1 with lu conditions true -> ifid_flush=1, idex_flush=1, pc_write=1, flush_events=1, stall_cycles unchanged. branch_taken pulsed during VSTALL -> ignored, freeze continues.
- **Reset mid-operation:** enter VSTALL with VL=3, assert reset on the 3rd frozen cycle -> outputs show the reset values immediately. After deassert: IDLE, normal set, both counters 0.
- **Saturation:** with CNT_W=4, hold lu true for 20 cycles -> stall_cycles stops at 15.
